// File: rtl/pipe_sel_stage.sv
// N-way WIDTH-bit registered select stage with valid/ready handshake, flush and sticky select-error flag.
// Define PIPE_SEL_SKID_EN to add a second (skid) entry so in_ready no longer depends on out_ready.
module pipe_sel_stage #(
  parameter  int N     = 4,
  parameter  int WIDTH = 32,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         count,
  output logic               sel_err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1
`ifdef PIPE_SEL_SKID_EN
    , FULL = 2'd2
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   head_q;
  logic [WIDTH-1:0]   sel_word;
  logic               sel_hit;
  logic               sel_err_q, sel_err_d;
  logic               accept, xfer;
  logic               load_head_in;
`ifdef PIPE_SEL_SKID_EN
  logic [WIDTH-1:0]   skid_q;
  logic               load_skid_in, load_head_skid;
`endif

  // Out-of-range selects match no slice and fall through to all-zero data.
  always_comb begin
    sel_word = '0;
    sel_hit  = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (in_sel == SEL_W'(k)) begin
        sel_word = in_data[k*WIDTH +: WIDTH];
        sel_hit  = 1'b1;
      end
    end
  end

  assign out_valid = (state_q != EMPTY);
  assign out_data  = head_q;
  assign sel_err   = sel_err_q;
  assign xfer      = out_valid && out_ready;
  assign accept    = in_valid && in_ready && !flush;

`ifdef PIPE_SEL_SKID_EN
  assign in_ready = (state_q != FULL) && !flush;
  assign count    = (state_q == FULL) ? 2'd2 : ((state_q == ONE) ? 2'd1 : 2'd0);
`else
  assign in_ready = (!out_valid || out_ready) && !flush;
  assign count    = {1'b0, state_q == ONE};
`endif

  always_comb begin
    state_d      = state_q;
    load_head_in = 1'b0;
`ifdef PIPE_SEL_SKID_EN
    load_skid_in   = 1'b0;
    load_head_skid = 1'b0;
`endif
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d      = ONE;
            load_head_in = 1'b1;
          end
        end
        ONE: begin
`ifdef PIPE_SEL_SKID_EN
          if (accept && xfer) begin
            load_head_in = 1'b1;
          end else if (accept) begin
            state_d      = FULL;
            load_skid_in = 1'b1;
          end else if (xfer) begin
            state_d = EMPTY;
          end
`else
          // Acceptance while occupied implies the head drains this cycle.
          if (accept) begin
            load_head_in = 1'b1;
          end else if (xfer) begin
            state_d = EMPTY;
          end
`endif
        end
`ifdef PIPE_SEL_SKID_EN
        FULL: begin
          if (xfer) begin
            state_d        = ONE;
            load_head_skid = 1'b1;
          end
        end
`endif
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    sel_err_d = sel_err_q;
    if (flush) begin
      sel_err_d = 1'b0;
    end else if (accept && !sel_hit) begin
      sel_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_err_q <= sel_err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
`ifdef PIPE_SEL_SKID_EN
      skid_q <= '0;
`endif
    end else begin
      if (load_head_in) begin
        head_q <= sel_word;
      end
`ifdef PIPE_SEL_SKID_EN
      else if (load_head_skid) begin
        head_q <= skid_q;
      end
      if (load_skid_in) begin
        skid_q <= sel_word;
      end
`endif
    end
  end

endmodule

// File: tb/tb_pipe_sel_stage.sv
// Self-checking bench for pipe_sel_stage: an N=4/32-bit and an N=3/8-bit instance share all control,
// checked every cycle against a queue model plus directed literal expectations.
module tb_pipe_sel_stage;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] in_data = '0;
  logic [1:0]   in_sel = '0;
  logic         in_valid = 1'b0;
  logic         flush = 1'b0;
  logic         out_ready = 1'b0;
  logic [23:0]  in_data3;

  logic         in_ready, out_valid, sel_err;
  logic [31:0]  out_data;
  logic [1:0]   count;
  logic         in_ready3, out_valid3, sel_err3;
  logic [7:0]   out_data3;
  logic [1:0]   count3;

  // The 3-input instance sees the low byte of each of the first three 32-bit words.
  assign in_data3 = {in_data[71:64], in_data[39:32], in_data[7:0]};

  pipe_sel_stage #(.N(4), .WIDTH(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .count(count), .sel_err(sel_err)
  );

  pipe_sel_stage #(.N(3), .WIDTH(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready3), .flush(flush), .out_data(out_data3), .out_valid(out_valid3),
    .out_ready(out_ready), .count(count3), .sel_err(sel_err3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d4;
    logic [7:0]  d3;
  } ent_t;

  ent_t q[$];
  bit   sticky3 = 1'b0;
  bit   m_acc = 1'b0;
  bit   m_flushed = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit modelReady();
    if (flush) return 1'b0;
`ifdef PIPE_SEL_SKID_EN
    return q.size() < 2;
`else
    return (q.size() == 0) || out_ready;
`endif
  endfunction

  // One compare-and-advance step per clock: check outputs at the falling edge, then advance the
  // model with the inputs that the next rising edge will consume.
  task automatic tick();
    bit   acc, xfer;
    ent_t e;
    @(negedge clk);
    if (!rst_n) begin
      q.delete();
      sticky3 = 1'b0;
    end
    checkOutput("out_valid", 32'(out_valid), 32'(q.size() > 0));
    checkOutput("count", 32'(count), 32'(q.size()));
    checkOutput("in_ready", 32'(in_ready), 32'(modelReady()));
    checkOutput("sel_err", 32'(sel_err), 32'd0);
    checkOutput("out_valid3", 32'(out_valid3), 32'(q.size() > 0));
    checkOutput("count3", 32'(count3), 32'(q.size()));
    checkOutput("in_ready3", 32'(in_ready3), 32'(modelReady()));
    checkOutput("sel_err3", 32'(sel_err3), 32'(sticky3));
    checkOutput("out_data_known", 32'($isunknown(out_data)), 32'd0);
    if (q.size() > 0) begin
      checkOutput("out_data", out_data, q[0].d4);
      checkOutput("out_data3", 32'(out_data3), 32'(q[0].d3));
    end else if (!rst_n) begin
      checkOutput("rst_out_data", out_data, 32'd0);
    end
    if (!rst_n) begin
      m_acc     = 1'b0;
      m_flushed = 1'b0;
    end else begin
      acc  = in_valid && modelReady();
      xfer = (q.size() > 0) && out_ready;
      if (flush) begin
        q.delete();
        sticky3 = 1'b0;
      end else begin
        if (xfer) void'(q.pop_front());
        if (acc) begin
          e.d4 = in_data[int'(in_sel)*32 +: 32];
          e.d3 = (in_sel < 2'd3) ? in_data[int'(in_sel)*32 +: 8] : 8'h00;
          q.push_back(e);
          if (in_sel == 2'd3) sticky3 = 1'b1;
        end
      end
      m_acc     = acc;
      m_flushed = flush;
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] s, input logic [127:0] d,
                               input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  // Random upstream keeps an unaccepted offer stable unless it was flushed away.
  task automatic applyRandom();
    @(posedge clk);
    #1;
    if (!(in_valid && !m_acc && !m_flushed)) begin
      in_valid = ($urandom_range(0, 9) < 7);
      in_sel   = 2'($urandom_range(0, 3));
      for (int k = 0; k < 4; k++) in_data[k*32 +: 32] = $urandom;
    end
    out_ready = ($urandom_range(0, 3) != 0);
    flush     = ($urandom_range(0, 19) == 0);
  endtask

  task automatic releaseReset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [127:0] pat;
    logic [31:0]  words[4];
    pat = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    words = '{32'hAAAA0000, 32'hBBBB0001, 32'hCCCC0002, 32'hDDDD0003};
    $display("[TB] start");

    repeat (2) @(posedge clk);
    tick();
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_out_data", out_data, 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_count", 32'(count), 32'd0);
    releaseReset();
    tick();
    checkOutput("post_reset_in_ready", 32'(in_ready), 32'd1);

    applyStimulus(1'b1, 2'd2, pat, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 2'd0, pat, 1'b1, 1'b0);
    tick();
    checkOutput("basic_data", out_data, 32'hCCCC0002);
    checkOutput("basic_valid", 32'(out_valid), 32'd1);
    checkOutput("basic_data3", 32'(out_data3), 32'h02);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 2'(i % 4), pat, 1'b1, 1'b0);
      tick();
      if (i > 0) begin
        checkOutput("stream_count", 32'(count), 32'd1);
        checkOutput("stream_data", out_data, words[(i - 1) % 4]);
      end
    end
    applyStimulus(1'b0, 2'd0, pat, 1'b1, 1'b0);
    tick();
    checkOutput("stream_last", out_data, 32'hDDDD0003);
    applyStimulus(1'b0, 2'd0, pat, 1'b1, 1'b0);
    tick();

    applyStimulus(1'b1, 2'd0, pat, 1'b0, 1'b0);
    tick();
    repeat (3) begin
      applyStimulus(1'b1, 2'd1, pat, 1'b0, 1'b0);
      tick();
    end
    checkOutput("bp_head", out_data, 32'hAAAA0000);
    checkOutput("bp_ready", 32'(in_ready), 32'd0);
`ifdef PIPE_SEL_SKID_EN
    checkOutput("bp_count", 32'(count), 32'd2);
`else
    checkOutput("bp_count", 32'(count), 32'd1);
`endif
    applyStimulus(1'b1, 2'd2, pat, 1'b1, 1'b0);
    tick();
    applyStimulus(!m_acc, 2'd2, pat, 1'b1, 1'b0);
    tick();
`ifdef PIPE_SEL_SKID_EN
    checkOutput("bp_release", out_data, 32'hBBBB0001);
`else
    checkOutput("bp_release", out_data, 32'hCCCC0002);
`endif
    repeat (3) begin
      applyStimulus(1'b0, 2'd0, pat, 1'b1, 1'b0);
      tick();
    end

    applyStimulus(1'b1, 2'd3, pat, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 2'd1, pat, 1'b1, 1'b0);
    tick();
    checkOutput("oor_data3", 32'(out_data3), 32'h00);
    checkOutput("oor_err3", 32'(sel_err3), 32'd1);
    checkOutput("oor_data4", out_data, 32'hDDDD0003);
    applyStimulus(1'b0, 2'd0, pat, 1'b1, 1'b0);
    tick();
    checkOutput("oor_sticky", 32'(sel_err3), 32'd1);
    checkOutput("oor_next3", 32'(out_data3), 32'h01);

    applyStimulus(1'b1, 2'd0, pat, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 2'd1, pat, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 2'd2, pat, 1'b1, 1'b1);
    tick();
    checkOutput("flush_ready", 32'(in_ready), 32'd0);
    checkOutput("flush_pre_err3", 32'(sel_err3), 32'd1);
`ifdef PIPE_SEL_SKID_EN
    checkOutput("flush_pre_count", 32'(count), 32'd2);
`else
    checkOutput("flush_pre_count", 32'(count), 32'd1);
`endif
    applyStimulus(1'b0, 2'd0, pat, 1'b1, 1'b0);
    tick();
    checkOutput("flush_count", 32'(count), 32'd0);
    checkOutput("flush_valid", 32'(out_valid), 32'd0);
    checkOutput("flush_err3", 32'(sel_err3), 32'd0);
    repeat (2) begin
      applyStimulus(1'b0, 2'd0, pat, 1'b1, 1'b0);
      tick();
    end
    checkOutput("flush_nothing", 32'(out_valid), 32'd0);

    applyStimulus(1'b1, 2'd0, pat, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 2'd0, pat, 1'b0, 1'b0);
    #2;
    checkOutput("async_pre_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_valid", 32'(out_valid), 32'd0);
    checkOutput("async_count", 32'(count), 32'd0);
    checkOutput("async_data", out_data, 32'd0);
    tick();
    releaseReset();
    tick();
    applyStimulus(1'b1, 2'd3, pat, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 2'd0, pat, 1'b1, 1'b0);
    tick();
    checkOutput("resume_data", out_data, 32'hDDDD0003);
    checkOutput("resume_count", 32'(count), 32'd1);

    repeat (3000) begin
      applyRandom();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
